// File: rtl/read_txn_tracker.sv
// read_txn_tracker: passive monitor for one ready/valid read channel pair.
// Keeps an in-order queue of outstanding read requests, pairs each response
// beat with its request address, reports per-transaction latency and raises
// sticky protocol-error flags (overflow, orphan response, timeout).
module read_txn_tracker #(
  parameter int unsigned addr_width     = 32,
  parameter int unsigned data_width     = 32,
  parameter int unsigned depth          = 4,
  parameter int unsigned timeout_cycles = 50,
  parameter int unsigned cnt_width      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      raddr_valid,
  input  logic                      raddr_ready,
  input  logic [addr_width-1:0]     raddr,
  input  logic                      rdata_valid,
  input  logic                      rdata_ready,
  input  logic [data_width-1:0]     rdata,
  output logic                      txn_valid,
  output logic [addr_width-1:0]     txn_addr,
  output logic [data_width-1:0]     txn_data,
  output logic [cnt_width-1:0]      txn_latency,
  output logic [cnt_width-1:0]      txn_count,
  output logic [$clog2(depth):0]    outstanding,
  output logic                      overflow_err,
  output logic                      orphan_err,
  output logic                      timeout_err
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned OccW = PtrW + 1;

  // Queue storage; contents are only meaningful below the occupancy count,
  // so the arrays carry no reset.
  logic [addr_width-1:0] addr_mem [depth];
  logic [cnt_width-1:0]  ts_mem   [depth];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]       occ_q, occ_d;
  logic [cnt_width-1:0]  cnt_q;

  logic                  txn_valid_q;
  logic [addr_width-1:0] txn_addr_q;
  logic [data_width-1:0] txn_data_q;
  logic [cnt_width-1:0]  txn_latency_q;
  logic [cnt_width-1:0]  txn_count_q;
  logic                  overflow_q, orphan_q, timeout_q;

  logic                  req_hs, rsp_hs;
  logic                  q_empty, q_full;
  logic                  push, pop;
  logic [cnt_width-1:0]  head_age;

  // Handshake decode and push/pop qualification against current occupancy.
  always_comb begin
    req_hs   = raddr_valid & raddr_ready;
    rsp_hs   = rdata_valid & rdata_ready;
    q_empty  = (occ_q == '0);
    q_full   = (occ_q == OccW'(depth));
    // Only entries present before this edge can be popped.
    pop      = rsp_hs & ~q_empty;
    // A full queue still accepts a request when the head leaves this cycle.
    push     = req_hs & (~q_full | pop);
    head_age = cnt_q - ts_mem[rd_ptr_q];
  end

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  // Queue entry write: request address plus its handshake timestamp.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= raddr;
      ts_mem[wr_ptr_q]   <= cnt_q;
    end
  end

  // Control state, timestamp counter, report registers and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      cnt_q         <= '0;
      txn_valid_q   <= 1'b0;
      txn_addr_q    <= '0;
      txn_data_q    <= '0;
      txn_latency_q <= '0;
      txn_count_q   <= '0;
      overflow_q    <= 1'b0;
      orphan_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      cnt_q       <= cnt_q + cnt_width'(1);
      txn_valid_q <= pop;
      if (pop) begin
        txn_addr_q    <= addr_mem[rd_ptr_q];
        txn_data_q    <= rdata;
        txn_latency_q <= head_age;
        txn_count_q   <= txn_count_q + cnt_width'(1);
      end
      if (req_hs && q_full && !rsp_hs) overflow_q <= 1'b1;
      if (rsp_hs && q_empty)           orphan_q   <= 1'b1;
      if (!q_empty && (head_age >= cnt_width'(timeout_cycles))) timeout_q <= 1'b1;
    end
  end

  // Output drive.
  always_comb begin
    txn_valid    = txn_valid_q;
    txn_addr     = txn_addr_q;
    txn_data     = txn_data_q;
    txn_latency  = txn_latency_q;
    txn_count    = txn_count_q;
    outstanding  = occ_q;
    overflow_err = overflow_q;
    orphan_err   = orphan_q;
    timeout_err  = timeout_q;
  end

endmodule

// File: tb/tb_read_txn_tracker.sv
// Directed self-checking bench for read_txn_tracker (default parameters).
module tb_read_txn_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        raddr_valid = 1'b0, raddr_ready = 1'b0;
  logic [31:0] raddr = '0;
  logic        rdata_valid = 1'b0, rdata_ready = 1'b0;
  logic [31:0] rdata = '0;
  logic        txn_valid;
  logic [31:0] txn_addr, txn_data;
  logic [15:0] txn_latency, txn_count;
  logic [2:0]  outstanding;
  logic        overflow_err, orphan_err, timeout_err;

  int checks = 0;
  int errors = 0;

  read_txn_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .raddr_valid  (raddr_valid),
    .raddr_ready  (raddr_ready),
    .raddr        (raddr),
    .rdata_valid  (rdata_valid),
    .rdata_ready  (rdata_ready),
    .rdata        (rdata),
    .txn_valid    (txn_valid),
    .txn_addr     (txn_addr),
    .txn_data     (txn_data),
    .txn_latency  (txn_latency),
    .txn_count    (txn_count),
    .outstanding  (outstanding),
    .overflow_err (overflow_err),
    .orphan_err   (orphan_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so inputs may change and outputs be sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic en, input logic [31:0] a);
    raddr_valid = en;
    raddr_ready = en;
    raddr       = a;
  endtask

  task automatic rsp(input logic en, input logic [31:0] d);
    rdata_valid = en;
    rdata_ready = en;
    rdata       = d;
  endtask

  task automatic do_reset();
    req(1'b0, '0);
    rsp(1'b0, '0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b0;
    checks++;
    if ({txn_valid, txn_addr, txn_data, txn_latency, txn_count, outstanding,
         overflow_err, orphan_err, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b addr=%h cnt=%0d occ=%0d err=%b%b%b want all 0",
               txn_valid, txn_addr, txn_count, outstanding, overflow_err, orphan_err, timeout_err);
    end
  endtask

  task automatic test_single();
    req(1'b1, 32'h10);
    tick();
    req(1'b0, '0);
    checks++;
    if (outstanding !== 3'd1) begin
      errors++; $display("FAIL single_occ: got %0d want 1", outstanding);
    end
    tick();
    tick();
    rsp(1'b1, 32'h0050_0093);
    tick();
    rsp(1'b0, '0);
    checks++;
    if (txn_valid !== 1'b1 || txn_addr !== 32'h10 || txn_data !== 32'h0050_0093) begin
      errors++;
      $display("FAIL single_report: got v=%b a=%h d=%h want v=1 a=00000010 d=00500093",
               txn_valid, txn_addr, txn_data);
    end
    checks++;
    if (txn_latency !== 16'd3 || txn_count !== 16'd1 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL single_lat: got lat=%0d cnt=%0d occ=%0d want lat=3 cnt=1 occ=0",
               txn_latency, txn_count, outstanding);
    end
    tick();
    checks++;
    if (txn_valid !== 1'b0 || txn_addr !== 32'h10 || txn_latency !== 16'd3) begin
      errors++;
      $display("FAIL single_hold: got v=%b a=%h lat=%0d want v=0 a=00000010 lat=3",
               txn_valid, txn_addr, txn_latency);
    end
  endtask

  task automatic test_in_order();
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 32'(i * 4));
      tick();
    end
    req(1'b0, '0);
    checks++;
    if (outstanding !== 3'd4) begin
      errors++; $display("FAIL inorder_peak: got %0d want 4", outstanding);
    end
    // Requests at edges 0..3, responses at edges 4..7: each latency is 4.
    for (int i = 0; i < 4; i++) begin
      rsp(1'b1, 32'hA0 + 32'(i));
      tick();
      checks++;
      if (txn_valid !== 1'b1 || txn_addr !== 32'(i * 4) || txn_data !== 32'hA0 + 32'(i) ||
          txn_latency !== 16'd4 || txn_count !== 16'(2 + i)) begin
        errors++;
        $display("FAIL inorder_%0d: got v=%b a=%h d=%h lat=%0d cnt=%0d want v=1 a=%h d=%h lat=4 cnt=%0d",
                 i, txn_valid, txn_addr, txn_data, txn_latency, txn_count,
                 32'(i * 4), 32'hA0 + 32'(i), 2 + i);
      end
    end
    rsp(1'b0, '0);
    checks++;
    if (outstanding !== 3'd0 || {overflow_err, orphan_err, timeout_err} !== 3'b000) begin
      errors++;
      $display("FAIL inorder_end: got occ=%0d err=%b%b%b want occ=0 err=000",
               outstanding, overflow_err, orphan_err, timeout_err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req(1'b1, 32'h100 + 32'(i * 4));
      tick();
    end
    req(1'b0, '0);
    checks++;
    if (overflow_err !== 1'b1 || outstanding !== 3'd4) begin
      errors++;
      $display("FAIL overflow: got ovf=%b occ=%0d want ovf=1 occ=4", overflow_err, outstanding);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 32'h100 + 32'(i * 4));
      tick();
    end
    req(1'b1, 32'h110);
    rsp(1'b1, 32'h1);
    tick();
    req(1'b0, '0);
    checks++;
    if (overflow_err !== 1'b0 || outstanding !== 3'd4 || txn_valid !== 1'b1 ||
        txn_addr !== 32'h100) begin
      errors++;
      $display("FAIL full_simul: got ovf=%b occ=%0d v=%b a=%h want ovf=0 occ=4 v=1 a=00000100",
               overflow_err, outstanding, txn_valid, txn_addr);
    end
    for (int i = 0; i < 4; i++) begin
      rsp(1'b1, 32'h2 + 32'(i));
      tick();
      checks++;
      if (txn_valid !== 1'b1 || txn_addr !== 32'h104 + 32'(i * 4) || txn_count !== 16'(2 + i)) begin
        errors++;
        $display("FAIL full_drain_%0d: got v=%b a=%h cnt=%0d want v=1 a=%h cnt=%0d",
                 i, txn_valid, txn_addr, txn_count, 32'h104 + 32'(i * 4), 2 + i);
      end
    end
    rsp(1'b0, '0);
    checks++;
    if (outstanding !== 3'd0 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL full_end: got occ=%0d ovf=%b want occ=0 ovf=0", outstanding, overflow_err);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    req(1'b1, 32'h200);
    rsp(1'b1, 32'hDEAD);
    tick();
    req(1'b0, '0);
    rsp(1'b0, '0);
    checks++;
    if (txn_valid !== 1'b0 || orphan_err !== 1'b1 || txn_count !== 16'd0 ||
        outstanding !== 3'd1) begin
      errors++;
      $display("FAIL orphan: got v=%b orph=%b cnt=%0d occ=%0d want v=0 orph=1 cnt=0 occ=1",
               txn_valid, orphan_err, txn_count, outstanding);
    end
    rsp(1'b1, 32'h55);
    tick();
    rsp(1'b0, '0);
    checks++;
    if (txn_valid !== 1'b1 || txn_addr !== 32'h200 || txn_data !== 32'h55 ||
        txn_count !== 16'd1 || txn_latency !== 16'd1) begin
      errors++;
      $display("FAIL orphan_pair: got v=%b a=%h d=%h cnt=%0d lat=%0d want v=1 a=00000200 d=00000055 cnt=1 lat=1",
               txn_valid, txn_addr, txn_data, txn_count, txn_latency);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req(1'b1, 32'h300);
    tick();
    req(1'b0, '0);
    for (int i = 1; i < 50; i++) tick();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_early: got %b want 0 at age 49", timeout_err);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_set: got %b want 1 at age 50", timeout_err);
    end
    for (int i = 51; i < 55; i++) tick();
    rsp(1'b1, 32'h77);
    tick();
    rsp(1'b0, '0);
    checks++;
    if (txn_valid !== 1'b1 || txn_addr !== 32'h300 || txn_latency !== 16'd55 ||
        outstanding !== 3'd0) begin
      errors++;
      $display("FAIL timeout_report: got v=%b a=%h lat=%0d occ=%0d want v=1 a=00000300 lat=55 occ=0",
               txn_valid, txn_addr, txn_latency, outstanding);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 32'h400 + 32'(i * 4));
      tick();
    end
    req(1'b0, '0);
    checks++;
    if (outstanding !== 3'd3 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got occ=%0d to=%b want occ=3 to=1", outstanding, timeout_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (outstanding !== 3'd0 || {overflow_err, orphan_err, timeout_err} !== 3'b000 ||
        txn_count !== 16'd0 || txn_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got occ=%0d err=%b%b%b cnt=%0d v=%b want all 0",
               outstanding, overflow_err, orphan_err, timeout_err, txn_count, txn_valid);
    end
    rsp(1'b1, 32'h99);
    tick();
    rsp(1'b0, '0);
    checks++;
    if (orphan_err !== 1'b1 || txn_valid !== 1'b0 || txn_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_orphan: got orph=%b v=%b cnt=%0d want orph=1 v=0 cnt=0",
               orphan_err, txn_valid, txn_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_in_order();
    test_overflow();
    test_full_simul();
    test_orphan();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
